// File: rtl/fpu_norm_pkg.sv
// Shared definitions for the FPU normalization shifter: widths, the legal
// shift range and the payload carried between the two pipeline stages.
package fpu_norm_pkg;

    localparam int MW        = 55;   // mantissa width
    localparam int EW        = 11;   // biased exponent width
    localparam int SHIFT_W   = 6;    // width of the leading-zero count
    localparam int MAX_SHIFT = 54;   // largest legal leading-zero count
    localparam int SEL_W     = 3;    // shift-select bits consumed per stage

    // Status that travels with a beat.
    typedef struct packed {
        logic underflow;   // exponent clamped at zero, result denormal
        logic err;         // leading-zero count out of range
        logic zero;        // all-zero mantissa detected
    } norm_flags_t;

    // Stage payload. eff is the shift still to be applied; each stage
    // consumes its own 3-bit slice of it.
    typedef struct packed {
        logic [MW-1:0]      data;
        logic [EW-1:0]      exp;
        logic [SHIFT_W-1:0] eff;
        norm_flags_t        flags;
    } norm_payload_t;

endpackage

// File: rtl/norm_shift_decoder_if.sv
// Valid/ready bus of the normalization shifter: input beat towards the
// block and normalized result out of it.
interface norm_shift_decoder_if #(
    parameter int MW = fpu_norm_pkg::MW,
    parameter int EW = fpu_norm_pkg::EW
);
    import fpu_norm_pkg::*;

    logic               In_Valid_i;
    logic               In_Ready_o;
    logic [SHIFT_W-1:0] Shift_Amt_i;
    logic [MW-1:0]      Data_i;
    logic [EW-1:0]      Exp_i;
    logic               Out_Valid_o;
    logic               Out_Ready_i;
    logic [MW-1:0]      Data_o;
    logic [EW-1:0]      Exp_o;
    logic               Underflow_o;
    logic               Err_o;
    logic               Zero_o;

    // Block side.
    modport slave (
        input  In_Valid_i, Shift_Amt_i, Data_i, Exp_i, Out_Ready_i,
        output In_Ready_o, Out_Valid_o, Data_o, Exp_o, Underflow_o, Err_o, Zero_o
    );

    // Producer/consumer side.
    modport master (
        output In_Valid_i, Shift_Amt_i, Data_i, Exp_i, Out_Ready_i,
        input  In_Ready_o, Out_Valid_o, Data_o, Exp_o, Underflow_o, Err_o, Zero_o
    );

endinterface

// File: rtl/norm_shift_stage.sv
// One pipeline register with an embedded left shift. The mantissa is shifted
// by eff[SEL_LSB +: 3] * STEP on the way into the register; the rest of the
// payload passes through. Holds its content while the successor stalls.
module norm_shift_stage
    import fpu_norm_pkg::*;
#(
    parameter int SEL_LSB = 0,   // lowest eff bit consumed by this stage
    parameter int STEP    = 1    // bit distance per select increment
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  norm_payload_t in_payload,
    output logic          out_valid,
    input  logic          out_ready,
    output norm_payload_t out_payload
);

    logic                valid_reg;
    norm_payload_t       payload_reg;
    norm_payload_t       payload_next;
    logic [SEL_W-1:0]    sel;
    logic [MW-1:0]       cand [2**SEL_W];

    assign sel = in_payload.eff[SEL_LSB +: SEL_W];

    // Every shift candidate this stage can produce; vacated LSBs fill with 0
    // and bits shifted past the MSB are dropped.
    generate
        for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_cand
            assign cand[gi] = in_payload.data << (gi * STEP);
        end
    endgenerate

    // Payload to capture: incoming beat with its mantissa shifted.
    always_comb begin
        payload_next      = in_payload;
        payload_next.data = cand[sel];
    end

    // Room for a new beat when empty or when the held beat moves on now.
    assign in_ready = !valid_reg || out_ready;

    // Stage register; cleared immediately on reset, discarding any beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg   <= 1'b0;
            payload_reg <= '0;
        end else if (in_ready) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                payload_reg <= payload_next;
            end
        end
    end

    assign out_valid   = valid_reg;
    assign out_payload = payload_reg;

endmodule

// File: rtl/norm_shift_decoder.sv
// Two-stage mantissa normalizer. Clamps the leading-zero shift to the
// exponent (denormal result), flags out-of-range shift counts, then applies
// the shift as a coarse byte step followed by a fine bit step.
// Optional feature macro: NORM_SHIFT_ZERO_DETECT_EN -- when defined, an
// all-zero mantissa bypasses normalization and raises Zero_o.
module norm_shift_decoder #(
    parameter int MW = fpu_norm_pkg::MW,
    parameter int EW = fpu_norm_pkg::EW
) (
    input  logic                 clk,
    input  logic                 rst,
    norm_shift_decoder_if.slave  bus
);
    import fpu_norm_pkg::*;

    logic [MW-1:0]      data_in;
    logic [EW-1:0]      exp_in;
    logic [SHIFT_W-1:0] shift_in;
    logic               shift_err;
    logic               shift_clamp;
    logic               mant_zero;
    norm_payload_t      dec_payload;

    logic               s1_in_ready;
    logic               s1_valid;
    norm_payload_t      s1_payload;
    logic               s2_in_ready;
    logic               s2_valid;
    norm_payload_t      s2_payload;
    logic               eff_unused;

    assign data_in  = bus.Data_i;
    assign exp_in   = bus.Exp_i;
    assign shift_in = bus.Shift_Amt_i;

    assign shift_err   = shift_in > SHIFT_W'(MAX_SHIFT);
    assign shift_clamp = EW'(shift_in) > exp_in;

`ifdef NORM_SHIFT_ZERO_DETECT_EN
    assign mant_zero = (data_in == '0);
`else
    assign mant_zero = 1'b0;
`endif

    // Decode the beat: effective shift, resulting exponent and flags. A zero
    // mantissa (when detected) wins over a bad count; both force a zero result.
    always_comb begin
        dec_payload = '0;
        if (mant_zero) begin
            dec_payload.flags.zero = 1'b1;
        end else if (shift_err) begin
            dec_payload.flags.err = 1'b1;
        end else if (shift_clamp) begin
            // exp_in < shift_in <= MAX_SHIFT, so it fits the shift field.
            dec_payload.data            = data_in;
            dec_payload.eff             = exp_in[SHIFT_W-1:0];
            dec_payload.flags.underflow = 1'b1;
        end else begin
            dec_payload.data = data_in;
            dec_payload.eff  = shift_in;
            dec_payload.exp  = exp_in - EW'(shift_in);
        end
    end

    // Coarse stage: shift by eff[5:3] whole bytes.
    norm_shift_stage #(
        .SEL_LSB (3),
        .STEP    (8)
    ) u_coarse (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (bus.In_Valid_i),
        .in_ready    (s1_in_ready),
        .in_payload  (dec_payload),
        .out_valid   (s1_valid),
        .out_ready   (s2_in_ready),
        .out_payload (s1_payload)
    );

    // Fine stage: shift by eff[2:0] bits.
    norm_shift_stage #(
        .SEL_LSB (0),
        .STEP    (1)
    ) u_fine (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (s1_valid),
        .in_ready    (s2_in_ready),
        .in_payload  (s1_payload),
        .out_valid   (s2_valid),
        .out_ready   (bus.Out_Ready_i),
        .out_payload (s2_payload)
    );

    // The shift amount is fully spent once the fine stage has applied it.
    assign eff_unused = ^s2_payload.eff;

    assign bus.In_Ready_o  = s1_in_ready;
    assign bus.Out_Valid_o = s2_valid;
    assign bus.Data_o      = s2_payload.data;
    assign bus.Exp_o       = s2_payload.exp;
    assign bus.Underflow_o = s2_payload.flags.underflow;
    assign bus.Err_o       = s2_payload.flags.err;
`ifdef NORM_SHIFT_ZERO_DETECT_EN
    assign bus.Zero_o      = s2_payload.flags.zero;
`else
    assign bus.Zero_o      = 1'b0 & s2_payload.flags.zero;
`endif

endmodule
